prog_loader16: RTL and testbench

Byte-stream program loader sitting directly upstream of the 16-bit core and its 26-bit instruction memory. It accepts a length-prefixed byte stream over a valid/ready handshake and assembles 26-bit instruction words. It writes those words to consecutive instruction-memory addresses starting at 0, then releases the core by asserting `core_run`. This replaces file-based program preload for hardware bring-up.

---
 rtl/calcu16_pkg.sv | 25 ++
 rtl/byte_assembler.sv | 30 +++
 rtl/prog_loader16.sv | 111 +++++++++++
 tb/tb_prog_loader16.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calcu16_pkg.sv
// rtl/calcu16_pkg.sv - shared widths, opcodes and loader state encoding for the calcu16 core
package calcu16_pkg;

    localparam int INSTR_W = 26;
    localparam int ADDR_W  = 16;

    localparam logic [3:0] ADD   = 4'd1;
    localparam logic [3:0] ADDI  = 4'd2;
    localparam logic [3:0] JMP   = 4'd3;
    localparam logic [3:0] JEQ   = 4'd4;
    localparam logic [3:0] STORE = 4'd5;
    localparam logic [3:0] LOAD  = 4'd6;
    localparam logic [3:0] XOR   = 4'd7;
    localparam logic [3:0] AND   = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs big-endian bytes into 32-bit words, pulsing word_valid after the 4th byte
module byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_cnt,
    output logic [31:0] word,
    output logic        word_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= 2'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && (byte_cnt == 2'd3);
            if (clear) begin
                byte_cnt <= 2'd0;
            end else if (byte_valid) begin
                // counter wraps 3->0 so the next group starts cleanly
                byte_cnt <= byte_cnt + 2'd1;
                word     <= {word[23:0], byte_data};
            end
        end
    end

endmodule

// File: rtl/prog_loader16.sv
// rtl/prog_loader16.sv - length-prefixed byte-stream loader that fills instruction memory then releases the core
module prog_loader16 #(
    parameter int ADDR_W  = calcu16_pkg::ADDR_W,
    parameter int INSTR_W = calcu16_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               core_run
);

    import calcu16_pkg::*;

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic [7:0]        n_hi;
    logic [ADDR_W-1:0] n_words;
    logic [ADDR_W-1:0] idx;

    logic        xfer;
    logic        load_start;
    logic        asm_valid;
    logic [1:0]  byte_cnt;
    logic [31:0] asm_word;
    logic        asm_word_valid;
    logic        last_word;
    logic        unused_asm_hi;

    assign xfer       = in_valid && in_ready;
    assign load_start = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign asm_valid  = xfer && (state == ST_DATA);
    assign last_word  = (idx == (n_words - ADDR_W'(1)));

    byte_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (load_start),
        .byte_valid (asm_valid),
        .byte_data  (in_data),
        .byte_cnt   (byte_cnt),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    // the assembler holds the finished word through the WRITE cycle, so it feeds memory directly
    assign mem_we        = asm_word_valid;
    assign mem_addr      = idx;
    assign mem_wdata     = asm_word[INSTR_W-1:0];
    assign unused_asm_hi = ^asm_word[31:INSTR_W];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LEN_HI;
            ST_LEN_HI: if (xfer) state_nxt = ST_LEN_LO;
            ST_LEN_LO: if (xfer) state_nxt = ({n_hi, in_data} == 16'd0) ? ST_DONE : ST_DATA;
            ST_DATA:   if (xfer && (byte_cnt == 2'd3)) state_nxt = ST_WRITE;
            ST_WRITE:  state_nxt = last_word ? ST_DONE : ST_DATA;
            ST_DONE:   if (start) state_nxt = ST_LEN_HI;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // status outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            n_hi     <= 8'd0;
            n_words  <= '0;
            idx      <= '0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            core_run <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= state_nxt inside {ST_LEN_HI, ST_LEN_LO, ST_DATA};
            busy     <= !(state_nxt inside {ST_IDLE, ST_DONE});
            done     <= (state_nxt == ST_DONE);
            core_run <= (state_nxt == ST_DONE);

            if (load_start) begin
                err <= 1'b0;
                idx <= '0;
            end
            if ((state == ST_LEN_HI) && xfer) begin
                n_hi <= in_data;
            end
            if ((state == ST_LEN_LO) && xfer) begin
                n_words <= ADDR_W'({n_hi, in_data});
            end
            if (asm_valid && (byte_cnt == 2'd0) && (in_data[7:2] != 6'd0)) begin
                err <= 1'b1;
            end
            if (state == ST_WRITE) begin
                idx <= idx + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader16.sv
// tb/tb_prog_loader16.sv - self-checking bench for prog_loader16
module tb_prog_loader16;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int           len;
        logic [111:0] b;
        int           mode;
        int           exp_n;
        logic [25:0]  exp_w0;
        logic [25:0]  exp_wl;
        logic         exp_err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [25:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_run;

    int n_total = 0;
    int n_pass  = 0;
    logic [41:0] wq[$];
    vec_t vecs[5];

    prog_loader16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .core_run  (core_run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " in_ready"}, 32'(in_ready), 32'd0);
        check({name, " mem_we"}, 32'(mem_we), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " done"}, 32'(done), 32'd0);
        check({name, " err"}, 32'(err), 32'd0);
        check({name, " core_run"}, 32'(core_run), 32'd0);
        check({name, " mem_addr"}, 32'(mem_addr), 32'd0);
        check({name, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    function automatic bq_t vec_bytes(input int len, input logic [111:0] b);
        bq_t q;
        for (int k = 0; k < len; k++) q.push_back(b[8*(len-1-k) +: 8]);
        return q;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: always valid, 1: valid on alternate cycles, 2: random gaps
    task automatic feed(input bq_t bs, input int mode, input int start_at);
        int   i = 0;
        int   cyc = 0;
        logic rdy_s = 1'b0;
        while (cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (in_valid && rdy_s) i++;
            if (i >= bs.size()) begin
                in_valid = 1'b0;
                break;
            end
            if (!(in_valid && !rdy_s)) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (cyc % 2 == 1);
                    default: in_valid = ($urandom_range(0, 99) < 60);
                endcase
                in_data = in_valid ? bs[i] : 8'($urandom_range(0, 255));
            end
            start = (cyc == start_at);
            rdy_s = in_ready;
        end
        start = 1'b0;
        if (cyc >= 5000) begin
            n_total++;
            $display("FAIL feed_timeout: got %0d of %0d bytes sent", i, bs.size());
        end
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (done !== 1'b1 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check({name, " done_reached"}, 32'(done), 32'd1);
    endtask

    // reference: decode the stream directly from its format rules
    task automatic compare_load(input string name, input bq_t bs);
        int          n;
        bit          e;
        logic [31:0] w;
        n = int'({bs[0], bs[1]});
        e = 1'b0;
        check({name, " nwrites"}, 32'(wq.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            w = {bs[2+4*i], bs[3+4*i], bs[4+4*i], bs[5+4*i]};
            if (bs[2+4*i] > 8'd3) e = 1'b1;
            if (i < wq.size()) begin
                check($sformatf("%s addr[%0d]", name, i), 32'(wq[i][41:26]), 32'(i));
                check($sformatf("%s data[%0d]", name, i), 32'(wq[i][25:0]), 32'(w % 32'h0400_0000));
            end
        end
        check({name, " err"}, 32'(err), 32'(e));
        check({name, " core_run"}, 32'(core_run), 32'd1);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " in_ready"}, 32'(in_ready), 32'd0);
        wq.delete();
    endtask

    initial begin
        bq_t   bs;
        string nm;
        int    nw;
        logic [7:0] fb;

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{6,  112'h000100440005,             0, 1, 26'h0440005, 26'h0440005, 1'b0};
        vecs[1] = '{2,  112'h0000,                     0, 0, 26'h0,       26'h0,       1'b0};
        vecs[2] = '{6,  112'h0001FF123456,             0, 1, 26'h3123456, 26'h3123456, 1'b1};
        vecs[3] = '{10, 112'h000203FFFFFF00000001,     1, 2, 26'h3FFFFFF, 26'h0000001, 1'b0};
        vecs[4] = '{14, 112'h00030100000A0200000B00123456, 1, 3, 26'h100000A, 26'h0123456, 1'b0};

        for (int v = 0; v < 5; v++) begin
            nm = $sformatf("vec%0d", v);
            if (v == 0) begin
                do_start();
            end else begin
                @(negedge clk);
                start = 1'b1;
                check({nm, " core_run_before_start"}, 32'(core_run), 32'd1);
                @(negedge clk);
                start = 1'b0;
                check({nm, " core_run_after_start"}, 32'(core_run), 32'd0);
                check({nm, " in_ready_after_start"}, 32'(in_ready), 32'd1);
                check({nm, " done_after_start"}, 32'(done), 32'd0);
                check({nm, " err_cleared"}, 32'(err), 32'd0);
            end
            bs = vec_bytes(vecs[v].len, vecs[v].b);
            feed(bs, vecs[v].mode, -1);
            if (vecs[v].exp_n == 0) check({nm, " done_after_two"}, 32'(done), 32'd1);
            wait_done(nm);
            check({nm, " tbl_nwrites"}, 32'(wq.size()), 32'(vecs[v].exp_n));
            if (vecs[v].exp_n > 0 && wq.size() == vecs[v].exp_n) begin
                check({nm, " tbl_w0"}, 32'(wq[0][25:0]), 32'(vecs[v].exp_w0));
                check({nm, " tbl_last_addr"}, 32'(wq[vecs[v].exp_n-1][41:26]), 32'(vecs[v].exp_n - 1));
                check({nm, " tbl_last_data"}, 32'(wq[vecs[v].exp_n-1][25:0]), 32'(vecs[v].exp_wl));
            end
            check({nm, " tbl_err"}, 32'(err), 32'(vecs[v].exp_err));
            compare_load(nm, bs);
        end

        // err appears the cycle after the offending first byte
        do_start();
        bs = vec_bytes(2, 112'h0001);
        feed(bs, 0, -1);
        @(negedge clk);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        check("errseq err_before", 32'(err), 32'd0);
        check("errseq in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("errseq err_next_cycle", 32'(err), 32'd1);
        bs = vec_bytes(3, 112'h123456);
        feed(bs, 0, -1);
        wait_done("errseq");
        bs = vec_bytes(6, 112'h0001FF123456);
        compare_load("errseq", bs);

        // start pulsed mid-DATA must be ignored
        do_start();
        check("startdata err_cleared", 32'(err), 32'd0);
        bs = vec_bytes(10, 112'h00020011223300445566);
        feed(bs, 0, 6);
        wait_done("startdata");
        compare_load("startdata", bs);

        // reset after two of four words
        do_start();
        bs = vec_bytes(12, 112'h0004_01000001_02000002_0300);
        feed(bs, 0, -1);
        repeat (2) @(negedge clk);
        check("midreset writes_before", 32'(wq.size()), 32'd2);
        check("midreset in_ready_before", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        do_start();
        bs = vec_bytes(6, 112'h000102ABCDEF);
        feed(bs, 0, -1);
        wait_done("postreset");
        compare_load("postreset", bs);

        for (int r = 0; r < 6; r++) begin
            nm = $sformatf("rand%0d", r);
            nw = $urandom_range(1, 6);
            bs = {};
            bs.push_back(8'(nw >> 8));
            bs.push_back(8'(nw));
            for (int k = 0; k < nw; k++) begin
                fb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
                bs.push_back(fb);
                for (int j = 0; j < 3; j++) bs.push_back(8'($urandom_range(0, 255)));
            end
            do_start();
            feed(bs, 2, -1);
            wait_done(nm);
            compare_load(nm, bs);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
